multicycle_sequencer: RTL and testbench

Clocked control sequencer for the 16-bit multi-cycle CPU datapath. It steps each instruction through fetch, decode, execute, memory and write-back, and drives every datapath select and write enable. It stretches memory states on a ready handshake and counts retired instructions. It sits between the instruction register / ALU branch flag and the PC, IR, MDR, ALUReg, register file and memory port.

---
 rtl/multicycle_sequencer_if.sv | 47 ++++
 rtl/multicycle_sequencer.sv | 166 ++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_if.sv
// Control bus between the multi-cycle sequencer and the 16-bit CPU datapath.
// The master side is the sequencer; the slave side is the datapath and memory port.
interface multicycle_sequencer_if #(
  parameter int unsigned WORD_SIZE = 16
);
  logic [3:0]           opcode;
  logic [5:0]           func;
  logic                 bcond;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 pc_write_cond;
  logic                 ir_write;
  logic                 mdr_write;
  logic                 alureg_write;
  logic                 reg_write;
  logic                 mem_read;
  logic                 mem_write;
  logic                 i_or_d;
  logic                 mem_to_reg;
  logic                 alu_src_a;
  logic                 write_data;
  logic [1:0]           alu_src_b;
  logic [1:0]           imm_sel;
  logic [1:0]           reg_dst;
  logic [1:0]           pc_source;
  logic [3:0]           alu_op;
  logic                 inst_done;
  logic                 wwd;
  logic                 halted;
  logic [WORD_SIZE-1:0] num_inst;

  modport master (
    input  opcode, func, bcond, mem_ready,
    output pc_write, pc_write_cond, ir_write, mdr_write, alureg_write, reg_write,
           mem_read, mem_write, i_or_d, mem_to_reg, alu_src_a, write_data,
           alu_src_b, imm_sel, reg_dst, pc_source, alu_op,
           inst_done, wwd, halted, num_inst
  );

  modport slave (
    output opcode, func, bcond, mem_ready,
    input  pc_write, pc_write_cond, ir_write, mdr_write, alureg_write, reg_write,
           mem_read, mem_write, i_or_d, mem_to_reg, alu_src_a, write_data,
           alu_src_b, imm_sel, reg_dst, pc_source, alu_op,
           inst_done, wwd, halted, num_inst
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT with
// memory-ready stretching and a retired-instruction counter.
module multicycle_sequencer #(
  parameter int unsigned WORD_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  multicycle_sequencer_if.master bus
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_R   = 4'd15;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_ORR = 4'd3;
  localparam logic [3:0] ALU_LHI = 4'd8;
  localparam logic [3:0] ALU_BNE = 4'd9;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] num_inst_q;
  logic                 r_alu;
  logic                 unused_bcond;

  // The branch decision itself is made in the datapath via pc_write_cond.
  assign unused_bcond = bus.bcond;
  assign r_alu        = (bus.opcode == OP_R) && (bus.func < 6'd8);
  assign bus.num_inst = num_inst_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FETCH;
      num_inst_q <= '0;
    end else begin
      state_q <= state_d;
      if (bus.inst_done) num_inst_q <= num_inst_q + WORD_SIZE'(1);
    end
  end

  always_comb begin
    state_d           = state_q;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mdr_write     = 1'b0;
    bus.alureg_write  = 1'b0;
    bus.reg_write     = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.write_data    = 1'b0;
    bus.alu_src_b     = 2'd0;
    bus.imm_sel       = 2'd0;
    bus.reg_dst       = 2'd0;
    bus.pc_source     = 2'd0;
    bus.alu_op        = ALU_ADD;
    bus.inst_done     = 1'b0;
    bus.wwd           = 1'b0;
    bus.halted        = 1'b0;
    // Outputs are decoded only while out of reset so the datapath sees all-zero controls during reset.
    if (reset_n) begin
      case (state_q)
        FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'd1;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_d      = DECODE;
          end
        end
        DECODE: begin
          bus.alu_src_b    = 2'd2;
          bus.imm_sel      = 2'd1;
          bus.alureg_write = 1'b1;
          state_d          = EXEC;
          if (bus.opcode == OP_R && bus.func == FN_HLT) begin
            bus.inst_done = 1'b1;
            state_d       = HALT;
          end else if (bus.opcode == OP_JMP || bus.opcode == OP_JAL) begin
            bus.pc_write  = 1'b1;
            bus.pc_source = 2'd2;
            bus.inst_done = 1'b1;
            state_d       = FETCH;
            if (bus.opcode == OP_JAL) begin
              bus.alu_src_b = 2'd3;
              bus.reg_write = 1'b1;
              bus.reg_dst   = 2'd3;
            end
          end
        end
        EXEC: begin
          state_d = FETCH;
          if (bus.opcode <= 4'd3) begin
            bus.alu_src_a     = 1'b1;
            bus.alu_op        = ALU_BNE + bus.opcode;
            bus.pc_write_cond = 1'b1;
            bus.pc_source     = 2'd1;
            bus.inst_done     = 1'b1;
          end else if (bus.opcode >= OP_ADI && bus.opcode <= OP_SWD) begin
            bus.alu_src_a    = 1'b1;
            bus.alu_src_b    = 2'd2;
            bus.alureg_write = 1'b1;
            bus.imm_sel      = (bus.opcode == OP_ORI || bus.opcode == OP_LHI) ? 2'd0 : 2'd1;
            bus.alu_op       = (bus.opcode == OP_ORI) ? ALU_ORR :
                               (bus.opcode == OP_LHI) ? ALU_LHI : ALU_ADD;
            state_d          = (bus.opcode >= OP_LWD) ? MEM : WB;
          end else if (r_alu) begin
            bus.alu_src_a    = 1'b1;
            bus.alu_op       = bus.func[3:0];
            bus.alureg_write = 1'b1;
            state_d          = WB;
          end else if (bus.opcode == OP_R && (bus.func == FN_JPR || bus.func == FN_JRL)) begin
            bus.pc_write  = 1'b1;
            bus.pc_source = 2'd3;
            bus.inst_done = 1'b1;
            if (bus.func == FN_JRL) begin
              bus.reg_write = 1'b1;
              bus.reg_dst   = 2'd3;
            end
          end else begin
            bus.wwd       = (bus.opcode == OP_R) && (bus.func == FN_WWD);
            bus.inst_done = 1'b1;
          end
        end
        MEM: begin
          bus.i_or_d = 1'b1;
          if (bus.opcode == OP_LWD) begin
            bus.mem_read  = 1'b1;
            bus.mdr_write = bus.mem_ready;
            if (bus.mem_ready) state_d = WB;
          end else begin
            bus.mem_write  = 1'b1;
            bus.write_data = 1'b1;
            if (bus.mem_ready) begin
              bus.inst_done = 1'b1;
              state_d       = FETCH;
            end
          end
        end
        WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = (bus.opcode == OP_LWD);
          bus.reg_dst    = (bus.opcode == OP_R) ? 2'd2 : 2'd1;
          bus.inst_done  = 1'b1;
          state_d        = FETCH;
        end
        HALT: begin
          bus.halted = 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer.
module tb_multicycle_sequencer;
  logic clk;
  logic reset_n;
  logic rst8_n;
  int   total;
  int   bad;

  multicycle_sequencer_if #(.WORD_SIZE(16)) bus ();
  multicycle_sequencer_if #(.WORD_SIZE(8))  bus8 ();

  multicycle_sequencer #(.WORD_SIZE(16)) u_dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  // Narrow counter instance so counter wrap-around is reachable in a short run.
  multicycle_sequencer #(.WORD_SIZE(8))  u_dut8 (.clk(clk), .reset_n(rst8_n), .bus(bus8));

  typedef struct packed {
    logic mem_read, ir_write, pc_write, pc_write_cond, mdr_write, mem_write;
    logic reg_write, mem_to_reg, inst_done, wwd, halted;
    logic [1:0] reg_dst, pc_source;
    logic [3:0] alu_op;
  } tr_t;
  tr_t tr [32];

  logic [26:0] outs;
  assign outs = {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.mdr_write,
                 bus.alureg_write, bus.reg_write, bus.mem_read, bus.mem_write,
                 bus.i_or_d, bus.mem_to_reg, bus.alu_src_a, bus.write_data,
                 bus.alu_src_b, bus.imm_sel, bus.reg_dst, bus.pc_source,
                 bus.alu_op, bus.inst_done, bus.wwd, bus.halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one instruction from FETCH; fw/mw are the not-ready cycles in FETCH/MEM.
  task automatic run_inst(input logic [3:0] op, input logic [5:0] fn,
                          input int fw, input int mw, output int n);
    int   fc;
    int   mc;
    logic done;
    fc = 0; mc = 0; done = 1'b0; n = 0;
    bus.opcode = op;
    bus.func   = fn;
    while (!done && n < 32) begin
      if (bus.i_or_d) begin
        bus.mem_ready = (mc >= mw); mc++;
      end else if (bus.mem_read) begin
        bus.mem_ready = (fc >= fw); fc++;
      end else begin
        bus.mem_ready = 1'b0;
      end
      #1;
      tr[n] = {bus.mem_read, bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.mdr_write,
               bus.mem_write, bus.reg_write, bus.mem_to_reg, bus.inst_done, bus.wwd,
               bus.halted, bus.reg_dst, bus.pc_source, bus.alu_op};
      done = bus.inst_done;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0;
    #2;
    total++;
    if (outs !== 27'd0) begin bad++; $display("FAIL reset_outs: got %h want 0", outs); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    total++;
    if (bus.mem_read !== 1'b1) begin bad++; $display("FAIL reset_release_mem_read: got %b want 1", bus.mem_read); end
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) run_inst(4'd9, 6'd0, 0, 0, n);
    total++;
    if (bus.num_inst !== 16'd5) begin bad++; $display("FAIL preset_count: got %0d want 5", bus.num_inst); end
    bus.opcode = 4'd15; bus.func = 6'd0; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (bus.alu_src_a !== 1'b1) begin bad++; $display("FAIL exec_alu_src_a: got %b want 1", bus.alu_src_a); end
    reset_n = 1'b0;
    #1;
    total++;
    if (outs !== 27'd0 || bus.num_inst !== 16'd0) begin
      bad++; $display("FAIL reset_mid_exec: outs=%h num=%0d want 0/0", outs, bus.num_inst);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    total++;
    if (bus.mem_read !== 1'b1 || bus.i_or_d !== 1'b0) begin
      bad++; $display("FAIL exec_reset_to_fetch: mem_read=%b i_or_d=%b want 1/0", bus.mem_read, bus.i_or_d);
    end
    @(posedge clk); #1;
    bus.opcode = 4'd8;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus.mem_write !== 1'b1 || bus.i_or_d !== 1'b1) begin
      bad++; $display("FAIL swd_mem_state: mem_write=%b i_or_d=%b want 1/1", bus.mem_write, bus.i_or_d);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.mem_write !== 1'b0) begin bad++; $display("FAIL reset_mid_mem: mem_write=%b want 0", bus.mem_write); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    total++;
    if (bus.mem_write !== 1'b0 || bus.mdr_write !== 1'b0 || bus.mem_read !== 1'b1) begin
      bad++; $display("FAIL mem_abort: mem_write=%b mdr_write=%b mem_read=%b want 0/0/1",
                      bus.mem_write, bus.mdr_write, bus.mem_read);
    end
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int n;
    run_inst(4'd15, 6'd0, 0, 0, n);
    total++;
    if (n !== 4) begin bad++; $display("FAIL add_cycles: got %0d want 4", n); end
    total++;
    if (tr[3].reg_write !== 1'b1 || tr[3].reg_dst !== 2'd2) begin
      bad++; $display("FAIL add_wb: reg_write=%b reg_dst=%0d want 1/2", tr[3].reg_write, tr[3].reg_dst);
    end
    total++;
    if (bus.num_inst !== 16'd1) begin bad++; $display("FAIL add_count: got %0d want 1", bus.num_inst); end
  endtask

  task automatic test_lwd();
    int n;
    int irw;
    int mdrw;
    irw = 0; mdrw = 0;
    run_inst(4'd7, 6'd0, 2, 3, n);
    for (int i = 0; i < n; i++) begin
      irw  += int'(tr[i].ir_write);
      mdrw += int'(tr[i].mdr_write);
    end
    total++;
    if (n !== 10) begin bad++; $display("FAIL lwd_cycles: got %0d want 10", n); end
    total++;
    if (irw !== 1 || mdrw !== 1 || tr[8].mdr_write !== 1'b1) begin
      bad++; $display("FAIL lwd_pulses: ir_write=%0d mdr_write=%0d want 1/1 (mdr at cycle 8)", irw, mdrw);
    end
    total++;
    if (tr[9].mem_to_reg !== 1'b1 || tr[9].reg_dst !== 2'd1 || tr[9].reg_write !== 1'b1) begin
      bad++; $display("FAIL lwd_wb: mem_to_reg=%b reg_dst=%0d reg_write=%b want 1/1/1",
                      tr[9].mem_to_reg, tr[9].reg_dst, tr[9].reg_write);
    end
    total++;
    if (bus.num_inst !== 16'd2) begin bad++; $display("FAIL lwd_count: got %0d want 2", bus.num_inst); end
  endtask

  task automatic test_branch();
    int n;
    for (int b = 0; b < 2; b++) begin
      bus.bcond = b[0];
      run_inst(4'd1, 6'd0, 0, 0, n);
      total++;
      if (n !== 3) begin bad++; $display("FAIL beq_cycles bcond=%0d: got %0d want 3", b, n); end
      total++;
      if (tr[2].pc_write_cond !== 1'b1 || tr[2].pc_source !== 2'd1 ||
          tr[2].alu_op !== 4'd10 || tr[2].pc_write !== 1'b0) begin
        bad++; $display("FAIL beq_exec bcond=%0d: pwc=%b ps=%0d op=%0d pw=%b want 1/1/10/0",
                        b, tr[2].pc_write_cond, tr[2].pc_source, tr[2].alu_op, tr[2].pc_write);
      end
    end
    bus.bcond = 1'b0;
  endtask

  task automatic test_cycles();
    logic [3:0] ops [8] = '{4'd9, 4'd10, 4'd15, 4'd15, 4'd4, 4'd8, 4'd11, 4'd15};
    logic [5:0] fns [8] = '{6'd0, 6'd0, 6'd25, 6'd26, 6'd0, 6'd0, 6'd0, 6'd7};
    int         cyc [8] = '{2, 2, 3, 3, 4, 4, 3, 4};
    logic [1:0] ps  [8] = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    logic       rw  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int n;
    for (int k = 0; k < 8; k++) begin
      run_inst(ops[k], fns[k], 0, 0, n);
      total++;
      if (n !== cyc[k]) begin
        bad++; $display("FAIL cycles op=%0d fn=%0d: got %0d want %0d", ops[k], fns[k], n, cyc[k]);
      end else begin
        total++;
        if (tr[n-1].pc_source !== ps[k] || tr[n-1].reg_write !== rw[k]) begin
          bad++; $display("FAIL last_cycle op=%0d fn=%0d: pc_source=%0d reg_write=%b want %0d/%b",
                          ops[k], fns[k], tr[n-1].pc_source, tr[n-1].reg_write, ps[k], rw[k]);
        end
      end
    end
  endtask

  task automatic test_wwd_hlt();
    int n;
    int wc;
    wc = 0;
    bus.mem_ready = 1'b0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_inst(4'd15, 6'd28, 0, 0, n);
    for (int i = 0; i < n; i++) wc += int'(tr[i].wwd);
    total++;
    if (n !== 3 || wc !== 1 || tr[2].wwd !== 1'b1) begin
      bad++; $display("FAIL wwd: cycles=%0d pulses=%0d want 3/1", n, wc);
    end
    run_inst(4'd15, 6'd29, 0, 0, n);
    total++;
    if (n !== 2 || tr[1].halted !== 1'b0) begin
      bad++; $display("FAIL hlt_decode: cycles=%0d halted=%b want 2/0", n, tr[1].halted);
    end
    total++;
    if (bus.num_inst !== 16'd2) begin bad++; $display("FAIL hlt_count: got %0d want 2", bus.num_inst); end
    for (int i = 0; i < 6; i++) begin
      bus.mem_ready = i[0];
      #1;
      total++;
      if (bus.halted !== 1'b1 || bus.mem_read !== 1'b0 || bus.inst_done !== 1'b0) begin
        bad++; $display("FAIL halt_hold cyc=%0d: halted=%b mem_read=%b inst_done=%b want 1/0/0",
                        i, bus.halted, bus.mem_read, bus.inst_done);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    rst8_n = 1'b1;
    repeat (510) @(posedge clk);
    #1;
    total++;
    if (bus8.num_inst !== 8'hFF) begin bad++; $display("FAIL wrap_full: got %h want ff", bus8.num_inst); end
    @(posedge clk); #1;
    total++;
    if (bus8.num_inst !== 8'hFF) begin bad++; $display("FAIL wrap_hold: got %h want ff", bus8.num_inst); end
    @(posedge clk); #1;
    total++;
    if (bus8.num_inst !== 8'h00) begin bad++; $display("FAIL wrap_zero: got %h want 00", bus8.num_inst); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    rst8_n  = 1'b0;
    bus.opcode = 4'd0; bus.func = 6'd0; bus.bcond = 1'b0; bus.mem_ready = 1'b0;
    bus8.opcode = 4'd9; bus8.func = 6'd0; bus8.bcond = 1'b0; bus8.mem_ready = 1'b1;
    test_reset();
    test_add();
    test_lwd();
    test_branch();
    test_cycles();
    test_wwd_hlt();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
